// File: rtl/a2d_rr_scheduler.sv
// Round-robin sequencer sharing one SPI A2D across lft/rght/steer/batt channels.
// Optional A2D_AVG_EN: captured value is the average of the previous and new sample.
module a2d_rr_scheduler #(
    parameter logic [2:0] CH_LFT       = 3'd0,
    parameter logic [2:0] CH_RGHT      = 3'd4,
    parameter logic [2:0] CH_STEER     = 3'd5,
    parameter logic [2:0] CH_BATT      = 3'd6,
    parameter int         SETTLE_CLKS  = 8,
    parameter int         TIMEOUT_CLKS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] ld_cell_lft,
    output logic [11:0] ld_cell_rght,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic [1:0]  rr_ptr,
    output logic        busy,
    output logic        err
);
    localparam int GW = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {IDLE, SEL, GAP, RD} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          gap_zero, tmo_hit;
    logic          start_sel, start_rd, capture, abort;
    logic [2:0]    ch_code;
    logic [11:0]   cur_res, new_res;
    logic [3:0]    unused_rd_hi;

    assign unused_rd_hi = rd_data[15:12];
    assign gap_zero     = (gap_cnt == '0);
    assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (nxt) state_nxt = SEL;
            SEL:  if (done) state_nxt = GAP;
                  else if (tmo_hit) state_nxt = IDLE;
            GAP:  if (gap_zero) state_nxt = RD;
            RD:   if (done || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_sel = (state == IDLE) && nxt;
        start_rd  = (state == GAP) && gap_zero;
        capture   = (state == RD) && done;
        abort     = ((state == SEL) || (state == RD)) && !done && tmo_hit;
    end

    always_comb begin
        ch_code = CH_LFT;
        cur_res = ld_cell_lft;
        case (rr_ptr)
            2'd0: begin ch_code = CH_LFT;   cur_res = ld_cell_lft;  end
            2'd1: begin ch_code = CH_RGHT;  cur_res = ld_cell_rght; end
            2'd2: begin ch_code = CH_STEER; cur_res = steer_pot;    end
            2'd3: begin ch_code = CH_BATT;  cur_res = batt;         end
            default: ;
        endcase
    end

`ifdef A2D_AVG_EN
    logic [12:0] avg_sum;
    assign avg_sum = {1'b0, cur_res} + {1'b0, rd_data[11:0]};
    assign new_res = avg_sum[12:1];
`else
    logic [11:0] unused_cur;
    assign unused_cur = cur_res;
    assign new_res    = rd_data[11:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrt          <= 1'b0;
            cmd          <= 16'h0000;
            busy         <= 1'b0;
            err          <= 1'b0;
            rr_ptr       <= 2'd0;
            gap_cnt      <= '0;
            tmo_cnt      <= '0;
            ld_cell_lft  <= 12'h000;
            ld_cell_rght <= 12'h000;
            steer_pot    <= 12'h000;
            batt         <= 12'h000;
        end else begin
            wrt <= start_sel | start_rd;
            if (start_sel) begin
                cmd  <= {2'b00, ch_code, 11'h000};
                busy <= 1'b1;
            end
            // Timeout window restarts with every transaction launch
            if (start_sel || start_rd)
                tmo_cnt <= '0;
            else if ((state == SEL) || (state == RD))
                tmo_cnt <= tmo_cnt + TW'(1);
            // Loaded with SETTLE-1 so the read launches after exactly SETTLE idle clocks
            if ((state == SEL) && done)
                gap_cnt <= GW'(SETTLE_CLKS - 1);
            else if ((state == GAP) && !gap_zero)
                gap_cnt <= gap_cnt - GW'(1);
            if (capture || abort) begin
                busy   <= 1'b0;
                rr_ptr <= rr_ptr + 2'd1;
            end
            if (abort) err <= 1'b1;
            if (capture) begin
                case (rr_ptr)
                    2'd0: ld_cell_lft  <= new_res;
                    2'd1: ld_cell_rght <= new_res;
                    2'd2: steer_pot    <= new_res;
                    2'd3: batt         <= new_res;
                    default: ;
                endcase
            end
        end
    end
endmodule
